// File: rtl/sbox_share_scheduler_pkg.sv
// Shared definitions for the time-multiplexed S-box lane: AES S-box table,
// scheduler state encoding and datapath widths.
package sbox_share_scheduler_pkg;

  localparam int WORD_W  = 32;
  localparam int STATE_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_PASS = 2'd1,
    KW_PASS = 2'd2
  } sched_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/sbox_share_scheduler_sbox_word.sv
// One 32-bit S-box lane: four independent combinational byte S-boxes,
// byte positions preserved.
module sbox_share_scheduler_sbox_word
  import sbox_share_scheduler_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  output logic [WORD_W-1:0] o_word
);

  for (genvar g = 0; g < WORD_W / 8; g++) begin : g_byte
    assign o_word[8*g +: 8] = sbox_byte(i_word[8*g +: 8]);
  end

endmodule

// File: rtl/sbox_share_scheduler.sv
// Shares one 32-bit S-box lane between a 128-bit SubBytes requester (four
// word passes) and a 32-bit SubWord requester that may be slotted between passes.
module sbox_share_scheduler
  import sbox_share_scheduler_pkg::*;
#(
  parameter bit KEY_PRIORITY = 1'b1,
  parameter bit KEY_PREEMPT  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st_valid,
  output logic               st_ready,
  input  logic [STATE_W-1:0] st_data,
  output logic               st_done,
  output logic [STATE_W-1:0] st_result,
  input  logic               kw_valid,
  output logic               kw_ready,
  input  logic [WORD_W-1:0]  kw_word,
  output logic               kw_done,
  output logic [WORD_W-1:0]  kw_result,
  output logic               busy
);

  sched_state_e       r_state;
  logic [STATE_W-1:0] r_st_buf;
  logic [WORD_W-1:0]  r_kw_buf;
  logic [1:0]         r_cnt;
  logic               r_resume;
  logic               r_st_done;
  logic               r_kw_done;
  logic [STATE_W-1:0] r_st_result;
  logic [WORD_W-1:0]  r_kw_result;

  logic [WORD_W-1:0]  w_lane_in;
  logic [WORD_W-1:0]  w_lane_out;
  logic               w_idle;
  logic               w_st_pass;
  logic               w_st_ready;
  logic               w_kw_ready;
  logic               w_st_acc;
  logic               w_kw_acc;

  // Word cnt=i lives at bits [127-32i -: 32]; {~cnt, 5'd31} is that top index.
  always_comb begin
    w_idle     = (r_state == IDLE);
    w_st_pass  = (r_state == ST_PASS);
    w_st_ready = w_idle && !(kw_valid && KEY_PRIORITY);
    w_kw_ready = (w_idle && (KEY_PRIORITY || !st_valid)) || (w_st_pass && KEY_PREEMPT);
    w_st_acc   = st_valid && w_st_ready;
    w_kw_acc   = kw_valid && w_kw_ready;
    if (r_state == KW_PASS) begin
      w_lane_in = r_kw_buf;
    end else begin
      w_lane_in = r_st_buf[{~r_cnt, 5'd31} -: WORD_W];
    end
  end

  sbox_share_scheduler_sbox_word u_lane (
    .i_word (w_lane_in),
    .o_word (w_lane_out)
  );

  // Scheduler FSM with registered results and done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_st_buf    <= {STATE_W{1'b0}};
      r_kw_buf    <= {WORD_W{1'b0}};
      r_cnt       <= 2'd0;
      r_resume    <= 1'b0;
      r_st_done   <= 1'b0;
      r_kw_done   <= 1'b0;
      r_st_result <= {STATE_W{1'b0}};
      r_kw_result <= {WORD_W{1'b0}};
    end else begin
      r_st_done <= 1'b0;
      r_kw_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_kw_acc) begin
            r_kw_buf <= kw_word;
            r_resume <= 1'b0;
            r_state  <= KW_PASS;
          end else if (w_st_acc) begin
            r_st_buf <= st_data;
            r_cnt    <= 2'd0;
            r_state  <= ST_PASS;
          end else begin
            r_state <= IDLE;
          end
        end
        ST_PASS: begin
          r_st_result[{~r_cnt, 5'd31} -: WORD_W] <= w_lane_out;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_st_done <= 1'b1;
          end
          // A key taken on the last pass completes the state now and returns to IDLE.
          if (w_kw_acc) begin
            r_kw_buf <= kw_word;
            r_resume <= (r_cnt != 2'd3);
            r_state  <= KW_PASS;
          end else if (r_cnt == 2'd3) begin
            r_state <= IDLE;
          end else begin
            r_state <= ST_PASS;
          end
        end
        KW_PASS: begin
          r_kw_result <= w_lane_out;
          r_kw_done   <= 1'b1;
          r_state     <= r_resume ? ST_PASS : IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign st_ready  = w_st_ready;
  assign kw_ready  = w_kw_ready;
  assign st_done   = r_st_done;
  assign kw_done   = r_kw_done;
  assign st_result = r_st_result;
  assign kw_result = r_kw_result;
  assign busy      = (r_state != IDLE);

endmodule
